instr_encoder: RTL

INSTR_ENCODER -- requirements
Module: instr_encoder

---
 rtl/instr_pkg.sv | 33 +++
 rtl/instr_fifo2.sv | 53 +++++
 rtl/instr_encoder.sv | 83 ++++++++
 3 files changed

// File: rtl/instr_pkg.sv
// Shared immediate-format codes and per-format range limits for the instruction encoder.
package instr_pkg;

  typedef enum logic [1:0] {
    IMM_I = 2'b00,
    IMM_S = 2'b01,
    IMM_B = 2'b10,
    IMM_J = 2'b11
  } imm_src_e;

  localparam int signed IMM_I_MIN = -2048;
  localparam int signed IMM_I_MAX = 2047;
  localparam int signed IMM_S_MIN = -2048;
  localparam int signed IMM_S_MAX = 2047;
  localparam int signed IMM_B_MIN = -4096;
  localparam int signed IMM_B_MAX = 4094;
  localparam int signed IMM_J_MIN = -1048576;
  localparam int signed IMM_J_MAX = 1048574;

  localparam logic [31:0] MASK_I  = 32'hFFF0_0000;
  localparam logic [31:0] MASK_SB = 32'hFE00_0F80;
  localparam logic [31:0] MASK_J  = 32'hFFFF_F000;

  // Bit positions of base that the given format overwrites with immediate bits.
  function automatic logic [31:0] imm_mask(imm_src_e src);
    case (src)
      IMM_I:   return MASK_I;
      IMM_J:   return MASK_J;
      default: return MASK_SB;
    endcase
  endfunction

endpackage

// File: rtl/instr_fifo2.sv
// Two-entry result buffer; ready depends only on registered occupancy.
module instr_fifo2 #(
  parameter int W = 33
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_valid_i,
  output logic         push_ready_o,
  input  logic [W-1:0] push_data_i,
  output logic         pop_valid_o,
  input  logic         pop_ready_i,
  output logic [W-1:0] pop_data_o
);

  logic [W-1:0] mem_q [2];
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         push, pop;

  assign push_ready_o = (count_q != 2'd2);
  assign pop_valid_o  = (count_q != 2'd0);
  assign pop_data_o   = mem_q[rd_ptr_q];

  assign push = push_valid_i && push_ready_o;
  assign pop  = pop_valid_o && pop_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = ~wr_ptr_q;
    if (pop)  rd_ptr_d = ~rd_ptr_q;
    if (push && !pop)      count_d = count_q + 2'd1;
    else if (pop && !push) count_d = count_q - 2'd1;
  end

  // Entries are cleared on reset so the output word reads zero while empty.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
      for (int i = 0; i < 2; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push) mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Inserts a range-checked immediate into an instruction word and buffers the result.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           imm_src,
  input  logic [31:0]          imm,
  input  logic [31:0]          base,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_instr,
  output logic                 out_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  imm_src_e              src;
  logic signed [31:0]    imm_s;
  logic [31:0]           field;
  logic [31:0]           enc_instr;
  logic                  enc_err;
  logic                  accept;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;

  assign src   = imm_src_e'(imm_src);
  assign imm_s = signed'(imm);

  always_comb begin
    field   = '0;
    enc_err = 1'b0;
    case (src)
      IMM_I: begin
        field   = {imm[11:0], 20'b0};
        enc_err = (imm_s < IMM_I_MIN) || (imm_s > IMM_I_MAX);
      end
      IMM_S: begin
        field   = {imm[11:5], 13'b0, imm[4:0], 7'b0};
        enc_err = (imm_s < IMM_S_MIN) || (imm_s > IMM_S_MAX);
      end
      IMM_B: begin
        field   = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11], 7'b0};
        enc_err = (imm_s < IMM_B_MIN) || (imm_s > IMM_B_MAX) || imm[0];
      end
      default: begin
        field   = {imm[20], imm[10:1], imm[11], imm[19:12], 12'b0};
        enc_err = (imm_s < IMM_J_MIN) || (imm_s > IMM_J_MAX) || imm[0];
      end
    endcase
    // A rejected immediate leaves its field zero rather than a truncated value.
    enc_instr = (base & ~imm_mask(src)) | (enc_err ? 32'b0 : field);
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (accept && enc_err && (err_cnt_q != {ERR_CNT_W{1'b1}}))
      err_cnt_d = err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk) begin
    if (reset) err_cnt_q <= '0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;

  instr_fifo2 #(.W(33)) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .push_valid_i (in_valid),
    .push_ready_o (in_ready),
    .push_data_i  ({enc_err, enc_instr}),
    .pop_valid_o  (out_valid),
    .pop_ready_i  (out_ready),
    .pop_data_o   ({out_err, out_instr})
  );

endmodule
